// File: rtl/kt8_pkg.sv
// +----------------------------------------------------------------------+
// | Module      : kt8_pkg                                                |
// | Description : Shared FSM state type and owner encodings for the      |
// |               KT8 data-RAM arbiter.                                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package kt8_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_IO  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/kt8_arb_pick.sv
// +----------------------------------------------------------------------+
// | Module      : kt8_arb_pick                                           |
// | Description : Winner selection for the KT8 arbiter. Fixed priority   |
// |               with IO starvation guard by default; round-robin when  |
// |               KT8_ARB_RR_EN is defined.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module kt8_arb_pick
    import kt8_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic io_req,
    input  logic grant_en,
    output logic winner
);

`ifdef KT8_ARB_RR_EN
    logic r_last_grant;

    always_comb begin
        winner = OWN_CPU;
        if (cpu_req && io_req)
            winner = ~r_last_grant;
        else if (io_req)
            winner = OWN_IO;
    end

    // Starts at IO so that the first contested grant goes to the CPU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_last_grant <= OWN_IO;
        else if (grant_en)
            r_last_grant <= winner;
    end
`else
    localparam int                  c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    logic [c_cnt_w-1:0] r_starve;

    always_comb begin
        winner = OWN_CPU;
        if (cpu_req && io_req)
            winner = (r_starve == c_limit) ? OWN_IO : OWN_CPU;
        else if (io_req)
            winner = OWN_IO;
    end

    // Counts contested losses by IO; saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (grant_en) begin
            if (winner == OWN_IO)
                r_starve <= '0;
            else if (io_req && (r_starve != c_limit))
                r_starve <= r_starve + c_cnt_w'(1);
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/kt8_ram_arbiter.sv
// +----------------------------------------------------------------------+
// | Module      : kt8_ram_arbiter                                        |
// | Description : Two-requester (CPU, IO) arbiter for a shared           |
// |               synchronous data RAM; one transaction per 3 cycles.    |
// |               Define KT8_ARB_RR_EN for round-robin arbitration.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module kt8_ram_arbiter
    import kt8_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   w_winner;
    logic   w_grant_en;

    assign w_grant_en = (r_state == IDLE) && (cpu_req || io_req);

    kt8_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .io_req   (io_req),
        .grant_en (w_grant_en),
        .winner   (w_winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= OWN_CPU;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_en)
                r_owner <= w_winner;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_en) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decode the registered state, so an async reset zeroes them at once.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        cpu_ack   = 1'b0;
        io_ack    = 1'b0;
        cpu_rdata = '0;
        io_rdata  = '0;
        case (r_state)
            ACCESS: begin
                if (r_owner == OWN_CPU) begin
                    ram_addr  = cpu_addr;
                    ram_wdata = cpu_wdata;
                    ram_we    = cpu_we;
                end else begin
                    ram_addr  = io_addr;
                    ram_wdata = io_wdata;
                    ram_we    = io_we;
                end
            end
            DONE: begin
                if (r_owner == OWN_CPU) begin
                    cpu_ack   = 1'b1;
                    cpu_rdata = ram_rdata;
                end else begin
                    io_ack    = 1'b1;
                    io_rdata  = ram_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
